// File: rtl/sw_capture_fifo.sv
// Switch-word capture FIFO: samples sw_i on each rising edge of the debounced key strobe,
// queues it first-word-fall-through, counts presses and flags dropped words.
module sw_capture_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       key_cap_i,
    input  logic [DATA_W-1:0]          sw_i,
    input  logic                       rd_en_i,
    input  logic                       clr_ovf_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [7:0]                 press_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t            state, state_nxt;
    logic              press;
    logic              pop, wr, drop;
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    // Edge guard: a held strobe raises exactly one press, on entry to ARMED.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        press     = 1'b0;
        case (state)
            IDLE: if (key_cap_i) begin
                state_nxt = ARMED;
                press     = 1'b1;
            end
            ARMED: if (!key_cap_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign valid_o   = (count_o != '0);
    assign full_o    = (count_o == FULL_CNT);
    assign rd_data_o = mem[rd_ptr];

    // A pop in the same cycle frees the head slot, so a press into a full FIFO is still accepted.
    assign pop  = rd_en_i && valid_o;
    assign wr   = press && (!full_o || pop);
    assign drop = press && full_o && !pop;

    always_ff @(posedge clk_i) begin
        if (wr) mem[wr_ptr] <= sw_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_o     <= '0;
            overflow_o  <= 1'b0;
            press_cnt_o <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop)      count_o <= count_o + 1'b1;
            else if (pop && !wr) count_o <= count_o - 1'b1;
            if (drop)           overflow_o <= 1'b1;
            else if (clr_ovf_i) overflow_o <= 1'b0;
            if (press) press_cnt_o <= press_cnt_o + 8'd1;
        end
    end
endmodule

// File: tb/tb_sw_capture_fifo.sv
// Directed bench for sw_capture_fifo: stimulus pushes expected words into a scoreboard,
// a negedge monitor checks every pop; flags and counters are checked inline.
module tb_sw_capture_fifo;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_cap = 1'b0;
    logic [DATA_W-1:0] sw = '0;
    logic              rd_en = 1'b0;
    logic              clr_ovf = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              valid, full, overflow;
    logic [2:0]        count;
    logic [7:0]        press_cnt;

    int vectors = 0;
    int errors  = 0;
    logic [DATA_W-1:0] sb[$];

    sw_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .key_cap_i(key_cap), .sw_i(sw),
        .rd_en_i(rd_en), .clr_ovf_i(clr_ovf), .rd_data_o(rd_data),
        .valid_o(valid), .full_o(full), .count_o(count),
        .overflow_o(overflow), .press_cnt_o(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic press_word(input logic [DATA_W-1:0] w, input bit accepted);
        sw = w; key_cap = 1'b1;
        step();
        key_cap = 1'b0;
        if (accepted) sb.push_back(w);
        step();
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) step();
        rd_en = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [2:0] c, input logic ov, input logic [7:0] pc);
        check({name, ".count"}, 32'(count), 32'(c));
        check({name, ".valid"}, 32'(valid), 32'(c != 0));
        check({name, ".full"}, 32'(full), 32'(c == 3'd4));
        check({name, ".overflow"}, 32'(overflow), 32'(ov));
        check({name, ".press_cnt"}, 32'(press_cnt), 32'(pc));
    endtask

    // Monitor: every accepted pop must return the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n && valid && rd_en) begin
            if (sb.size() == 0) check("pop_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
            else check("pop_data", 32'(rd_data), 32'(sb.pop_front()));
        end
    end

    initial begin
        #12;
        check_state("reset", 3'd0, 1'b0, 8'd0);
        rst_n = 1'b1;
        step();

        // single capture, latency 1
        sw = 16'hA5C3; key_cap = 1'b1;
        step();
        key_cap = 1'b0;
        sb.push_back(16'hA5C3);
        check_state("single", 3'd1, 1'b0, 8'd1);
        check("single.rd_data", 32'(rd_data), 32'h0000_A5C3);
        step();
        pop_n(1);
        check_state("single_pop", 3'd0, 1'b0, 8'd1);

        // held strobe counts once
        sw = 16'h1234; key_cap = 1'b1;
        repeat (5) step();
        key_cap = 1'b0;
        sb.push_back(16'h1234);
        step();
        check_state("held", 3'd1, 1'b0, 8'd2);
        pop_n(1);

        // fill and overflow; the drop coincides with clr_ovf, set wins
        for (int i = 1; i <= 4; i++) press_word(16'(i), 1'b1);
        sw = 16'd5; key_cap = 1'b1; clr_ovf = 1'b1;
        step();
        key_cap = 1'b0; clr_ovf = 1'b0;
        check_state("overflow", 3'd4, 1'b1, 8'd7);
        step();
        check_state("overflow_sticky", 3'd4, 1'b1, 8'd7);
        pop_n(4);
        check_state("drained", 3'd0, 1'b1, 8'd7);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);

        // simultaneous press and pop while full
        for (int i = 6; i <= 9; i++) press_word(16'(i), 1'b1);
        sw = 16'hA; key_cap = 1'b1; rd_en = 1'b1;
        step();
        key_cap = 1'b0; rd_en = 1'b0;
        sb.push_back(16'hA);
        check_state("full_simul", 3'd4, 1'b0, 8'd12);
        step();
        pop_n(4);
        check_state("full_simul_drain", 3'd0, 1'b0, 8'd12);

        // pointer wrap over 10 write/pop pairs
        for (int i = 0; i < 10; i++) begin
            press_word(16'(i), 1'b1);
            pop_n(1);
        end
        check_state("wrap", 3'd0, 1'b0, 8'd22);

        // simultaneous press and pop while partially filled
        press_word(16'h55, 1'b1);
        press_word(16'h66, 1'b1);
        sw = 16'h77; key_cap = 1'b1; rd_en = 1'b1;
        step();
        key_cap = 1'b0; rd_en = 1'b0;
        sb.push_back(16'h77);
        check_state("mid_simul", 3'd2, 1'b0, 8'd25);
        step();
        pop_n(2);

        // async reset with count=3 and overflow=1
        for (int i = 0; i < 4; i++) press_word(16'h11 * 16'(i + 1), 1'b1);
        press_word(16'h55, 1'b0);
        pop_n(1);
        check_state("pre_reset", 3'd3, 1'b1, 8'd30);
        #2 rst_n = 1'b0;
        #1 check_state("async_reset", 3'd0, 1'b0, 8'd0);
        #2 rst_n = 1'b1;
        sb.delete();
        step();
        pop_n(1);
        check_state("post_reset_pop", 3'd0, 1'b0, 8'd0);

        // key already high when reset releases
        sw = 16'hBEEF; key_cap = 1'b1;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
        key_cap = 1'b0;
        sb.push_back(16'hBEEF);
        check_state("key_at_release", 3'd1, 1'b0, 8'd1);
        step();
        pop_n(1);

        repeat (2) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule

// File: doc/sw_capture_fifo.md
SW_CAPTURE_FIFO -- requirements
Module: sw_capture_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, which is the captured switch word width.
REQ-002 SHALL have parameter DEPTH, default 4, which is the FIFO entry count; it is a power of two, at least 2.
REQ-003 SHALL have port clk_i, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, width 1: asynchronous, active-low reset.
REQ-005 SHALL have port key_cap_i, input, width 1: debounced key-confirm strobe from the key debounce stage.
REQ-006 SHALL have port sw_i, input, width DATA_W: switch word, sampled on a press event.
REQ-007 SHALL have port rd_en_i, input, width 1: consumer pop request.
REQ-008 SHALL have port clr_ovf_i, input, width 1: clears the sticky overflow flag.
REQ-009 SHALL have port rd_data_o, output, width DATA_W: head-of-FIFO word.
REQ-010 SHALL have port valid_o, output, width 1: FIFO non-empty.
REQ-011 SHALL have port full_o, output, width 1: FIFO holds DEPTH entries.
REQ-012 SHALL have port count_o, output, width $clog2(DEPTH)+1: current occupancy.
REQ-013 SHALL have port overflow_o, output, width 1: sticky flag meaning a press was dropped.
REQ-014 SHALL have port press_cnt_o, output, width 8: total detected presses, modulo 256.

Function
REQ-015 SHALL define a press event as a rising edge of key_cap_i: key_cap_i=1 in the current cycle and 0 in the previous cycle. A strobe held high for N cycles SHALL count as one event.
REQ-016 SHALL implement the edge guard as a two-state FSM: IDLE goes to ARMED when key_cap_i=1, raising the event in that cycle; ARMED goes to IDLE when key_cap_i=0.
REQ-017 SHALL, on an event, sample sw_i in that same cycle; the word becomes visible on rd_data_o with valid_o=1 one cycle later when the FIFO was empty (latency 1).
REQ-018 SHALL present rd_data_o as first-word-fall-through: rd_data_o is the oldest entry whenever valid_o=1, and its value is don't-care when valid_o=0.
REQ-019 SHALL pop the head when rd_en_i=1 and valid_o=1; the next entry appears on rd_data_o in the following cycle.
REQ-020 SHALL ignore rd_en_i when valid_o=0: no pointer change and no underflow flag.
REQ-021 SHALL write the sampled word on an event when full_o=0.
REQ-022 SHALL, on an event when full_o=1 with no pop in the same cycle, drop the word and set overflow_o=1 on the next cycle.
REQ-023 SHALL, on an event and a pop in the same cycle with full_o=1, perform both operations: the word is accepted, count_o is unchanged, and overflow_o does not change.
REQ-024 SHALL, on an event and a pop in the same cycle with the FIFO non-empty and non-full, perform both operations with count_o unchanged.
REQ-025 SHALL update count_o as follows: +1 on write only, -1 on pop only, and unchanged otherwise. It never exceeds DEPTH and never goes below 0.
REQ-026 SHALL drive full_o = (count_o==DEPTH) and valid_o = (count_o!=0), both registered-consistent with count_o in the same cycle.
REQ-027 SHALL use read and write pointers of width $clog2(DEPTH) that wrap modulo DEPTH with no gap.
REQ-028 SHALL increment press_cnt_o once per event, whether the word is accepted or dropped, wrapping from 255 to 0.
REQ-029 SHALL hold overflow_o at 1 until clr_ovf_i=1; clearing takes effect on the next cycle.
REQ-030 SHALL keep overflow_o=1 when clr_ovf_i=1 and a new drop occur in the same cycle, because the set has priority.

Reset
REQ-031 SHALL, while rst_n_i=0, immediately force valid_o=0, full_o=0, count_o=0, overflow_o=0, press_cnt_o=0, both pointers to 0, and the FSM to IDLE, independent of clk_i.
REQ-032 SHALL discard FIFO contents when reset is asserted mid-operation; storage need not be cleared.
REQ-033 SHALL treat a key_cap_i already high at reset release as an event on the first clock edge after release.

Verification
REQ-034 SHALL verify single capture: sw_i=16'hA5C3 with a 1-cycle key_cap_i pulse -> next cycle valid_o=1, rd_data_o=16'hA5C3, count_o=1, press_cnt_o=1.
REQ-035 SHALL verify held strobe: key_cap_i high for 5 cycles -> exactly one entry is written and press_cnt_o increments by 1.
REQ-036 SHALL verify fill and overflow: 5 separated pulses with sw_i=1,2,3,4,5 and no reads -> full_o=1, count_o=4, overflow_o=1, press_cnt_o=5; pops return 1,2,3,4, then valid_o=0.
REQ-037 SHALL verify simultaneous full: with count_o=4, an event and rd_en_i in the same cycle -> count_o stays 4, overflow_o stays 0, and the new word is read last.
REQ-038 SHALL verify pointer wrap: 10 write/pop pairs with sw_i=0..9 -> data returns in order 0..9 and count_o returns to 0.
REQ-039 SHALL verify asynchronous reset mid-operation: rst_n_i low for 3 ns with count_o=3 and overflow_o=1 -> all outputs are 0 before the next clk_i edge, and rd_en_i after release has no effect.
